// File: rtl/sdram_resp_pkg.sv
// Shared types and constants for the SDRAM-pin responder.
package sdram_resp_pkg;

  localparam int RD_LAT_MIN = 2;
  localparam int RD_LAT_MAX = 8;
  localparam int DQ_W       = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_e;

  typedef struct packed {
    logic            vld;
    logic            beat;
    logic [DQ_W-1:0] half;
  } rd_ent_t;

endpackage

// File: rtl/sdram_resp_rdpipe.sv
// Read-return pipeline: takes a captured word, emits low then high half
// rd_lat cycles after the read command, with matching output enable.
module sdram_resp_rdpipe
  import sdram_resp_pkg::*;
#(
  parameter int rd_lat = 2
) (
  input  logic              sdram_clk,
  input  logic              sdram_rst_n,
  input  logic              cap_vld,
  input  logic [2*DQ_W-1:0] cap_word,
  output logic [DQ_W-1:0]   sd_DQ_out,
  output logic [DQ_W-1:0]   sd_DQ_en
);

  // Capture lands one edge after the command, so rd_lat-1 stages remain.
  localparam int STAGES = rd_lat - 1;

  rd_ent_t         pipe_q [STAGES];
  rd_ent_t         pipe_d [STAGES];
  logic [DQ_W-1:0] hi_q, hi_d;
  rd_ent_t         in_ent;

  always_comb begin
    hi_d   = cap_vld ? cap_word[2*DQ_W-1:DQ_W] : hi_q;
    in_ent = '0;
    if (cap_vld) begin
      in_ent = '{vld: 1'b1, beat: 1'b0, half: cap_word[DQ_W-1:0]};
    end else if (pipe_q[0].vld && !pipe_q[0].beat) begin
      // beat0 entered last edge; its high half follows right behind
      in_ent = '{vld: 1'b1, beat: 1'b1, half: hi_q};
    end
    pipe_d[0] = in_ent;
    for (int i = 1; i < STAGES; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      hi_q <= '0;
      for (int i = 0; i < STAGES; i++) pipe_q[i] <= '0;
    end else begin
      hi_q <= hi_d;
      for (int i = 0; i < STAGES; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  // Entries are zero when invalid, so the data bus idles at 0.
  assign sd_DQ_out = pipe_q[STAGES-1].half;
  assign sd_DQ_en  = {DQ_W{pipe_q[STAGES-1].vld}};

endmodule

// File: rtl/sdram_responder.sv
// Memory endpoint for the ORCA SDRAM pin protocol: 2-beat writes, 2-beat reads.
// Define SDRAM_RESP_PROTCHK_EN to enable sticky protocol-error flag and counter.
module sdram_responder
  import sdram_resp_pkg::*;
#(
  parameter int sd_a_width  = 10,
  parameter int sd_dq_width = 16,
  parameter int mem_aw      = 6,
  parameter int rd_lat      = 2
) (
  input  logic                   sdram_clk,
  input  logic                   sdram_rst_n,
  input  logic                   sd_LD,
  input  logic                   sd_RW,
  input  logic [sd_a_width-1:0]  sd_A,
  input  logic [1:0]             sd_BWS,
  input  logic [sd_dq_width-1:0] sd_DQ_in,
  output logic [sd_dq_width-1:0] sd_DQ_out,
  output logic [sd_dq_width-1:0] sd_DQ_en,
  output logic                   proto_err,
  output logic [7:0]             err_cnt
);

  state_e                     state_q, state_d;
  logic [mem_aw-1:0]          idx_q, idx_d;
  logic                       rw_q, rw_d;
  logic                       wr0, wr1, cap_vld;
  logic [2*sd_dq_width-1:0]   mem_q [2**mem_aw];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rw_d    = rw_q;
    // A new command is legal anywhere except the cycle after acceptance.
    if (sd_LD && state_q != BEAT0) begin
      idx_d = sd_A[mem_aw-1:0];
      rw_d  = sd_RW;
    end
    case (state_q)
      IDLE:    if (sd_LD) state_d = BEAT0;
      BEAT0:   state_d = BEAT1;
      BEAT1:   state_d = sd_LD ? BEAT0 : IDLE;
      default: state_d = IDLE;
    endcase
    wr0     = (state_q == BEAT0) && !rw_q;
    wr1     = (state_q == BEAT1) && !rw_q;
    cap_vld = (state_q == BEAT0) &&  rw_q;
  end

  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rw_q    <= rw_d;
    end
  end

  // Storage is deliberately unreset; each beat commits its own bytes.
  always_ff @(posedge sdram_clk) begin
    if (wr0) begin
      if (!sd_BWS[0]) mem_q[idx_q][7:0]  <= sd_DQ_in[7:0];
      if (!sd_BWS[1]) mem_q[idx_q][15:8] <= sd_DQ_in[15:8];
    end
    if (wr1) begin
      if (!sd_BWS[0]) mem_q[idx_q][sd_dq_width+7:sd_dq_width]   <= sd_DQ_in[7:0];
      if (!sd_BWS[1]) mem_q[idx_q][sd_dq_width+15:sd_dq_width+8] <= sd_DQ_in[15:8];
    end
  end

  sdram_resp_rdpipe #(.rd_lat(rd_lat)) u_rdpipe (
    .sdram_clk   (sdram_clk),
    .sdram_rst_n (sdram_rst_n),
    .cap_vld     (cap_vld),
    .cap_word    (mem_q[idx_q]),
    .sd_DQ_out   (sd_DQ_out),
    .sd_DQ_en    (sd_DQ_en)
  );

  // Upper address bits alias onto the storage index.
  if (sd_a_width > mem_aw) begin : g_alias
    logic unused_a_hi;
    assign unused_a_hi = ^sd_A[sd_a_width-1:mem_aw];
  end

`ifdef SDRAM_RESP_PROTCHK_EN
  logic       viol;
  logic       proto_err_q, proto_err_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  assign viol = sd_LD && (state_q == BEAT0);

  always_comb begin
    proto_err_d = proto_err_q | viol;
    err_cnt_d   = err_cnt_q;
    if (viol && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      proto_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      proto_err_q <= proto_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign proto_err = proto_err_q;
  assign err_cnt   = err_cnt_q;
`else
  assign proto_err = 1'b0;
  assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_sdram_responder.sv
// Randomized bench: two responders (rd_lat 2 and 8) share one stimulus stream
// and are compared every cycle against a per-cycle expected-output schedule.
module tb_sdram_responder;

  localparam int NCYC = 4096;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        ld = 1'b0, rw = 1'b0;
  logic [9:0]  a = '0;
  logic [1:0]  bws = 2'b11;
  logic [15:0] dqi = '0;
  logic [15:0] dq2, en2, dq8, en8;
  logic        err2, err8;
  logic [7:0]  cnt2, cnt8;

  sdram_responder #(.rd_lat(2)) dut2 (
    .sdram_clk(clk), .sdram_rst_n(rst_n), .sd_LD(ld), .sd_RW(rw), .sd_A(a),
    .sd_BWS(bws), .sd_DQ_in(dqi), .sd_DQ_out(dq2), .sd_DQ_en(en2),
    .proto_err(err2), .err_cnt(cnt2));

  sdram_responder #(.rd_lat(8)) dut8 (
    .sdram_clk(clk), .sdram_rst_n(rst_n), .sd_LD(ld), .sd_RW(rw), .sd_A(a),
    .sd_BWS(bws), .sd_DQ_in(dqi), .sd_DQ_out(dq8), .sd_DQ_en(en8),
    .proto_err(err8), .err_cnt(cnt8));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] e_dq2 [NCYC];
  logic [15:0] e_dq8 [NCYC];
  bit          e_en2 [NCYC];
  bit          e_en8 [NCYC];
  logic [31:0] mdl   [64];
  int          n_tests = 0, n_fail = 0;
  bit          chk_on = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("en_lat2", {16'h0, en2}, {16'h0, {16{e_en2[cyc]}}});
      chk("dq_lat2", {16'h0, dq2}, {16'h0, e_dq2[cyc]});
      chk("en_lat8", {16'h0, en8}, {16'h0, {16{e_en8[cyc]}}});
      chk("dq_lat8", {16'h0, dq8}, {16'h0, e_dq8[cyc]});
    end
  end

  // One command slot: command cycle t, beat0 at t+1, beat1 at t+2 (returns
  // inside t+2 so the next command can share that cycle).
  task automatic issue(input bit r, input logic [9:0] adr, input logic [15:0] d0,
                       input logic [15:0] d1, input logic [1:0] b0,
                       input logic [1:0] b1, input bit viol);
    int          t, i;
    logic [31:0] w;
    t  = cyc;
    i  = int'(adr[5:0]);
    ld = 1'b1; rw = r; a = adr;
    if (r) begin
      w = mdl[i];
      e_dq2[t+2] = w[15:0];  e_en2[t+2] = 1'b1;
      e_dq2[t+3] = w[31:16]; e_en2[t+3] = 1'b1;
      e_dq8[t+8] = w[15:0];  e_en8[t+8] = 1'b1;
      e_dq8[t+9] = w[31:16]; e_en8[t+9] = 1'b1;
    end else begin
      if (!b0[0]) mdl[i][7:0]   = d0[7:0];
      if (!b0[1]) mdl[i][15:8]  = d0[15:8];
      if (!b1[0]) mdl[i][23:16] = d1[7:0];
      if (!b1[1]) mdl[i][31:24] = d1[15:8];
    end
    @(posedge clk); #1;
    ld = viol; rw = 1'($urandom); a = 10'($urandom);
    dqi = r ? 16'($urandom) : d0; bws = r ? 2'($urandom) : b0;
    @(posedge clk); #1;
    ld = 1'b0; rw = 1'($urandom); a = 10'($urandom);
    dqi = r ? 16'($urandom) : d1; bws = r ? 2'($urandom) : b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      ld = 1'b0; dqi = 16'($urandom); bws = 2'($urandom);
    end
  endtask

  task automatic chk_err(input string tag, input int n_viol);
    logic       e_err;
    logic [7:0] e_cnt;
`ifdef SDRAM_RESP_PROTCHK_EN
    e_err = (n_viol > 0);
    e_cnt = (n_viol > 255) ? 8'd255 : 8'(n_viol);
`else
    e_err = 1'b0;
    e_cnt = 8'd0;
`endif
    chk({tag, "_err2"}, {31'h0, err2}, {31'h0, e_err});
    chk({tag, "_cnt2"}, {24'h0, cnt2}, {24'h0, e_cnt});
    chk({tag, "_err8"}, {31'h0, err8}, {31'h0, e_err});
    chk({tag, "_cnt8"}, {24'h0, cnt8}, {24'h0, e_cnt});
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [9:0] ad;
    int         nv;
    for (int i = 0; i < NCYC; i++) begin
      e_dq2[i] = '0; e_dq8[i] = '0; e_en2[i] = 1'b0; e_en8[i] = 1'b0;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_dq2", {16'h0, dq2}, 32'h0);
    chk("rst_en2", {16'h0, en2}, 32'h0);
    chk("rst_dq8", {16'h0, dq8}, 32'h0);
    chk("rst_en8", {16'h0, en8}, 32'h0);
    chk_err("rst", 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_on = 1'b1;

    // Fill every location so later reads never hit undefined storage.
    for (int i = 0; i < 64; i++)
      issue(1'b0, 10'(i), 16'($urandom), 16'($urandom), 2'b00, 2'b00, 1'b0);

    // Full write then immediate read-back at t+2.
    issue(1'b0, 10'd5, 16'h1234, 16'hABCD, 2'b00, 2'b00, 1'b0);
    issue(1'b1, 10'd5, 16'h0, 16'h0, 2'b00, 2'b00, 1'b0);
    idle(10);
    // Byte-select masking.
    issue(1'b0, 10'd3, 16'hFFFF, 16'hFFFF, 2'b00, 2'b00, 1'b0);
    issue(1'b0, 10'd3, 16'h0000, 16'h0000, 2'b10, 2'b01, 1'b0);
    issue(1'b1, 10'd3, 16'h0, 16'h0, 2'b00, 2'b00, 1'b0);
    idle(3);
    // Upper address bits alias.
    issue(1'b0, 10'h041, 16'h5A5A, 16'hC3C3, 2'b00, 2'b00, 1'b0);
    idle(2);
    issue(1'b1, 10'h001, 16'h0, 16'h0, 2'b00, 2'b00, 1'b0);
    idle(10);

    // Strict R/W alternation, back-to-back.
    for (int k = 0; k < 64; k++)
      issue(1'(k % 2), 10'($urandom), 16'($urandom), 16'($urandom),
            2'($urandom), 2'($urandom), 1'b0);
    idle(10);
    // Random mix with random gaps.
    for (int k = 0; k < 48; k++) begin
      issue(1'($urandom), 10'($urandom), 16'($urandom), 16'($urandom),
            2'($urandom), 2'($urandom), 1'b0);
      idle($urandom_range(0, 3));
    end
    idle(10);
    chk_err("pre_viol", 0);

    // Violating LD during beat0 of writes (and some reads); data must be intact.
    nv = 0;
    for (int k = 0; k < 300; k++) begin
      ad = 10'($urandom);
      issue(1'b0, ad, 16'($urandom), 16'($urandom), 2'($urandom), 2'($urandom), 1'b1);
      nv++;
      if (k % 4 == 0) issue(1'b1, ad, 16'h0, 16'h0, 2'b00, 2'b00, 1'b0);
      if (k == 2) begin
        idle(1);
        chk_err("viol3", nv);
      end
    end
    idle(10);
    chk_err("viol300", nv);

    // Reset asserted in cycle t+2 of a read.
    chk_on = 1'b0;
    issue(1'b1, 10'd5, 16'h0, 16'h0, 2'b00, 2'b00, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_en2", {16'h0, en2}, 32'h0);
    chk("midrst_dq2", {16'h0, dq2}, 32'h0);
    chk("midrst_en8", {16'h0, en8}, 32'h0);
    chk_err("midrst", 0);
    idle(2);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      chk("postrst_en2", {16'h0, en2}, 32'h0);
      chk("postrst_en8", {16'h0, en8}, 32'h0);
    end
    @(posedge clk); #1;
    chk_on = 1'b1;
    issue(1'b1, 10'd5, 16'h0, 16'h0, 2'b00, 2'b00, 1'b0);
    idle(12);

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_responder.md
# sdram_responder

Synchronous, single-clock responder for the SDRAM-side pin protocol driven by the ORCA SDRAM interface controller: it samples `sd_LD`/`sd_RW`/`sd_A`/`sd_BWS`, accepts two-beat write bursts on the DQ input bus and returns two-beat read bursts with a fixed, parameterised latency. It sits at the far end of the `sd_*` pins. It serves as a synthesizable memory endpoint for FPGA prototyping and closed-loop system simulation of the SDRAM path (controller → pins → responder → read FIFO).

## Interface
- `sd_a_width`, 10, width of `sd_A`
- `sd_dq_width`, 16, width of one data beat; must equal 16, matching the 2-bit `sd_BWS`
- `mem_aw`, 6, internal storage address bits; depth is 2^`mem_aw` words of 2×`sd_dq_width`
- `rd_lat`, 2, cycles from read command to first read beat; legal range 2..8

Ports (direction, width, meaning):
- `sdram_clk`, in, 1, sole clock
- `sdram_rst_n`, in, 1, asynchronous active-low reset
- `sd_LD`, in, 1, command valid, active high
- `sd_RW`, in, 1, 1 = read, 0 = write; sampled with `sd_LD`
- `sd_A`, in, `sd_a_width`, word address; sampled with `sd_LD`
- `sd_BWS`, in, 2, active-low byte write selects, sampled per write beat
- `sd_DQ_in`, in, `sd_dq_width`, write data driven by the controller
- `sd_DQ_out`, out, `sd_dq_width`, read data to the controller
- `sd_DQ_en`, out, `sd_dq_width`, output enable per bit; all bits are always equal
- `proto_err`, out, 1, sticky protocol-violation flag
- `err_cnt`, out, 8, saturating protocol-violation count

## Operation
- Idle state: a cycle with `sd_LD`=1 is accepted. The responder then goes to BEAT0 and BEAT1, and returns to idle after BEAT1.
- Address: `idx` = `sd_A[mem_aw-1:0]`. Upper address bits are ignored, so addresses alias.
- Write accepted at cycle t:
  - t+1 delivers beat0, which maps to the low half of the word.
  - t+2 delivers beat1, which maps to the high half.
  - Each beat commits at its own clock edge.
  - `sd_BWS[0]`=0 writes bits 7:0 of the beat. `sd_BWS[1]`=0 writes bits 15:8. A deasserted byte select keeps the stored byte.
- Read accepted at cycle t:
  - The word at `idx` is captured at the end of cycle t+1, after any write commit at that edge.
  - Low half is driven in cycle t+`rd_lat`; high half in cycle t+`rd_lat`+1.
  - `sd_DQ_en` is all-ones exactly in those two cycles.
  - Outside read beats, `sd_DQ_out` is 0.
- Minimum command spacing is 2 cycles, so the next legal `sd_LD` is at t+2.
- Back-to-back commands at t and t+2 are supported in any read/write mix. Read pipeline entries overlap freely because `rd_lat` ≤ 8 and depth is provisioned for 4 in-flight reads.
- Read-after-write at t+2 to the same `idx` returns the new data. This follows from the capture at t+3, which is after the t+2 commit.
- `sd_LD`=1 while in BEAT0 is a violation:
  - The command is ignored.
  - The burst in progress is unaffected.
  - Handling under Configuration.
- Memory contents are not reset. A read of a never-written location returns an undefined value.

## Timing
- Reset values: `sd_DQ_out`=0, `sd_DQ_en`=0, `proto_err`=0, `err_cnt`=0. The FSM resets to idle and the read pipeline is cleared.
- Reset mid-write: beats already committed remain; later beats are dropped.
- Reset mid-read: pending beats are discarded, and `sd_DQ_en` is 0 from assertion onward.
- All outputs are registered; there are no combinational input-to-output paths.
- Write-to-storage latency is 1 edge per beat. Read latency is `rd_lat` cycles to beat0.

## Configuration
- `SDRAM_RESP_PROTCHK_EN` defined:
  - Each violation sets `proto_err`, which stays set until reset.
  - Each violation increments `err_cnt`, which saturates at 255.
- `SDRAM_RESP_PROTCHK_EN` undefined:
  - Violations are silently ignored.
  - `proto_err` and `err_cnt` are tied to 0, and the counter logic is removed.

## Structure
- Shared package `sdram_resp_pkg` holds:
  - FSM state enum: IDLE, BEAT0, BEAT1.
  - Read-pipeline entry struct: valid, beat select, data half.
  - Constants `RD_LAT_MIN`=2 and `RD_LAT_MAX`=8.
- One sub-module, `sdram_resp_rdpipe`:
  - A `rd_lat`-parameterised shift pipeline of captured words.
  - It emits the beat0/beat1 sequence and `sd_DQ_en`.
- Storage is an inferred register array in the top module.

## Test plan
- Write 0x1234/0xABCD to A=5 with BWS=00 on both beats, then read A=5 at t+2 → `sd_DQ_out`=0x1234 at t+4 and 0xABCD at t+5, `sd_DQ_en`=0xFFFF for exactly those 2 cycles.
- Write 0xFFFF/0xFFFF to A=3, then write 0x0000/0x0000 to A=3 with BWS=10 on beat0 and 01 on beat1 → a read returns 0xFF00/0x00FF.
- Write A=0x041, then read A=0x001 with `mem_aw`=6 → the read returns the aliased data.
- Alternate R/W every 2 cycles for 64 commands against a scoreboard with `rd_lat`=2 and `rd_lat`=8 → all reads match; no `sd_DQ_en` gaps or overlaps.
- Assert `sd_LD` at t+1 during a write, 300 times with the macro defined → burst data intact, `proto_err`=1, `err_cnt`=255. With the macro undefined → both outputs remain 0.
- Assert `sdram_rst_n`=0 in cycle t+2 of a read → `sd_DQ_en`=0 immediately, and no read beats appear after release.
